mesm6_mem_arbiter: RTL and testbench

- Shares one single-ported 48-bit main memory between the instruction bus (ibus_*) and data bus (dbus_*) of mesm6_core.
- Sits between the core and the memory controller.
- Serialises simultaneous requests and returns all dones for a cycle's request set in one common cycle, so the core's busy term clears once.
- Latches read data so each memory operation is performed exactly once per core request.

---
 rtl/mesm6_arb_pkg.sv | 14 +
 rtl/mesm6_word_cache.sv | 42 ++++
 rtl/mesm6_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mesm6_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_arb_pkg.sv
// Shared types and widths for the mesm6 instruction/data memory arbiter.
package mesm6_arb_pkg;

    localparam int MEM_ADDR_W = 15;
    localparam int MEM_DATA_W = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INSN = 2'd2,
        DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mesm6_word_cache.sv
// One-entry instruction word cache: a single tag/valid/data triple.
// Filled on every completed instruction fetch, invalidated by a data write
// to the cached address. Only instantiated when MESM6_ARB_WORD_CACHE_EN is set.
module mesm6_word_cache
    import mesm6_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval_en,
    input  logic [ADDR_W-1:0] inval_addr
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;

    // Fill wins over invalidate; the two never coincide since they come from different states.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (inval_en && (inval_addr == tag)) begin
            valid <= 1'b0;
        end
    end

    assign hit     = valid && (lookup_addr == tag);
    assign rd_data = data;

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the mesm6 instruction and
// data buses. A request set sampled in IDLE is served one memory op at a time
// and all dones for that set pulse together in DONE.
// Optional feature macro: MESM6_ARB_WORD_CACHE_EN (one-entry fetch word cache).
module mesm6_mem_arbiter
    import mesm6_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int IFETCH_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_output,
    output logic [DATA_W-1:0] dbus_input,
    output logic              dbus_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    arb_state_t        state, state_nxt;
    logic              pend_i, pend_d;
    logic              orig_i, orig_d;
    logic              op_wr;
    logic [ADDR_W-1:0] lat_iaddr, lat_daddr;
    logic [DATA_W-1:0] lat_wdata;

    logic              in_idle;
    logic              fetch_hit;
    logic              req_i, req_d;
    logic              orig_i_nxt, orig_d_nxt, op_wr_nxt;
    logic [ADDR_W-1:0] iaddr_nxt, daddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

`ifdef MESM6_ARB_WORD_CACHE_EN
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rdata;

    mesm6_word_cache #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_word_cache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (ibus_addr),
        .hit         (cache_hit),
        .rd_data     (cache_rdata),
        .fill_en     ((state == INSN) && mem_done),
        .fill_addr   (lat_iaddr),
        .fill_data   (mem_rdata),
        .inval_en    ((state == DATA) && mem_done && op_wr),
        .inval_addr  (lat_daddr)
    );
`else
    logic              cache_hit;
    assign cache_hit = 1'b0;
`endif

    // Request set and operands are only taken in IDLE; elsewhere the latched copies hold.
    always_comb begin
        in_idle    = (state == IDLE);
        fetch_hit  = ibus_fetch && cache_hit;
        req_i      = ibus_fetch && !fetch_hit;
        req_d      = dbus_read || dbus_write;
        orig_i_nxt = in_idle ? ibus_fetch  : orig_i;
        orig_d_nxt = in_idle ? req_d       : orig_d;
        op_wr_nxt  = in_idle ? dbus_write  : op_wr;
        iaddr_nxt  = in_idle ? ibus_addr   : lat_iaddr;
        daddr_nxt  = in_idle ? dbus_addr   : lat_daddr;
        wdata_nxt  = in_idle ? dbus_output : lat_wdata;
    end

    // Next-state decode: serve pending ops one at a time, then a single DONE cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_d && req_i)
                    state_nxt = (IFETCH_FIRST != 0) ? INSN : DATA;
                else if (req_d)
                    state_nxt = DATA;
                else if (req_i)
                    state_nxt = INSN;
                else if (ibus_fetch)
                    state_nxt = DONE;
                else
                    state_nxt = IDLE;
            end
            DATA: if (mem_done) state_nxt = pend_i ? INSN : DONE;
            INSN: if (mem_done) state_nxt = pend_d ? DATA : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, pending flags, registered strobes/dones and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend_i     <= 1'b0;
            pend_d     <= 1'b0;
            orig_i     <= 1'b0;
            orig_d     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            ibus_done  <= 1'b0;
            dbus_done  <= 1'b0;
            ibus_input <= '0;
            dbus_input <= '0;
        end else begin
            state     <= state_nxt;
            orig_i    <= orig_i_nxt;
            orig_d    <= orig_d_nxt;
            mem_read  <= (state_nxt == INSN) || ((state_nxt == DATA) && !op_wr_nxt);
            mem_write <= (state_nxt == DATA) && op_wr_nxt;
            ibus_done <= (state_nxt == DONE) && orig_i_nxt;
            dbus_done <= (state_nxt == DONE) && orig_d_nxt;

            if (in_idle) begin
                pend_i <= req_i;
                pend_d <= req_d;
`ifdef MESM6_ARB_WORD_CACHE_EN
                if (fetch_hit)
                    ibus_input <= cache_rdata;
`endif
            end

            if ((state == DATA) && mem_done) begin
                pend_d <= 1'b0;
                if (!op_wr)
                    dbus_input <= mem_rdata;
            end

            if ((state == INSN) && mem_done) begin
                pend_i     <= 1'b0;
                ibus_input <= mem_rdata;
            end
        end
    end

    // Operand latches and memory address/data; kept across reset on purpose.
    always_ff @(posedge clk) begin
        op_wr     <= op_wr_nxt;
        lat_iaddr <= iaddr_nxt;
        lat_daddr <= daddr_nxt;
        lat_wdata <= wdata_nxt;
        mem_addr  <= (state_nxt == INSN) ? iaddr_nxt : daddr_nxt;
        mem_wdata <= wdata_nxt;
    end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed self-checking bench for mesm6_mem_arbiter with a behavioural memory.
// Define MESM6_ARB_WORD_CACHE_EN to also exercise the fetch word cache.
module tb_mesm6_mem_arbiter;

    localparam logic [47:0] W_I1 = 48'o0123_4567_0123_4567;
    localparam logic [47:0] W_I2 = 48'h5555_AAAA_0001;
    localparam logic [47:0] W_D  = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] W_WR = 48'h1234_5678_9ABC;
    localparam logic [47:0] W_X  = 48'hFEDC_BA98_7654;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_fetch = 1'b0;
    logic [14:0] ibus_addr = '0;
    logic [47:0] ibus_input;
    logic        ibus_done;
    logic        dbus_read = 1'b0;
    logic        dbus_write = 1'b0;
    logic [14:0] dbus_addr = '0;
    logic [47:0] dbus_output = '0;
    logic [47:0] dbus_input;
    logic        dbus_done;
    logic        mem_read;
    logic        mem_write;
    logic [14:0] mem_addr;
    logic [47:0] mem_wdata;
    logic [47:0] mem_rdata;
    logic        mem_done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    mesm6_mem_arbiter #(.ADDR_W(15), .DATA_W(48), .IFETCH_FIRST(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ibus_input),
        .ibus_done   (ibus_done),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (dbus_input),
        .dbus_done   (dbus_done),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: done after mem_wait strobe cycles unless stalled.
    logic [47:0] mem_arr [0:511];
    int          mem_wait = 0;
    bit          stall = 1'b0;
    int          wcnt = 0;
    logic [14:0] rd_log[$];
    logic [14:0] wr_log[$];
    int          i_done_cnt = 0;
    int          d_done_cnt = 0;
    int          i_done_cyc = -1;
    int          d_done_cyc = -1;

    assign mem_done  = (mem_read || mem_write) && !stall && (wcnt == mem_wait);
    assign mem_rdata = mem_done ? mem_arr[mem_addr[8:0]] : 48'h0;

    always @(posedge clk) begin
        if (mem_done) begin
            wcnt <= 0;
            if (mem_read) rd_log.push_back(mem_addr);
            if (mem_write) begin
                wr_log.push_back(mem_addr);
                mem_arr[mem_addr[8:0]] <= mem_wdata;
            end
        end else if (mem_read || mem_write) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (ibus_done) begin
            i_done_cnt <= i_done_cnt + 1;
            i_done_cyc <= cyc;
        end
        if (dbus_done) begin
            d_done_cnt <= d_done_cnt + 1;
            d_done_cyc <= cyc;
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Core-side request: hold until a done is seen, release after the DONE cycle.
    task automatic do_req(input bit f, input bit r, input bit w,
                          input logic [14:0] ia, input logic [14:0] da,
                          input logic [47:0] wd, output int lat);
        int c0;
        @(posedge clk); #1;
        ibus_fetch = f; dbus_read = r; dbus_write = w;
        ibus_addr = ia; dbus_addr = da; dbus_output = wd;
        c0 = cyc;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ibus_done || dbus_done) begin
                lat = cyc - c0;
                break;
            end
        end
        @(posedge clk); #1;
        ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, ibus_done, dbus_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: strobes/dones=%b expected 0000", {mem_read, mem_write, ibus_done, dbus_done});
        end
        n_checks++;
        if (ibus_input !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_ibus_input: got %h expected 0", ibus_input);
        end
        n_checks++;
        if (dbus_input !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_dbus_input: got %h expected 0", dbus_input);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        int lat, br, bw, bi, bd;
        logic [14:0] a0;
        mem_wait = 1;
        mem_arr[9'o100] = W_I1;
        br = rd_log.size(); bw = wr_log.size(); bi = i_done_cnt; bd = d_done_cnt;
        do_req(1, 0, 0, 15'o00100, 15'o0, 48'h0, lat);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a0 = (rd_log.size() > br) ? rd_log[br] : 15'bx;
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd_log.size() - br !== 1) begin n_fail++; $display("FAIL fetch_read_count: got %0d expected 1", rd_log.size() - br); end
        n_checks++;
        if (a0 !== 15'o00100) begin n_fail++; $display("FAIL fetch_read_addr: got %o expected 00100", a0); end
        n_checks++;
        if (wr_log.size() - bw !== 0) begin n_fail++; $display("FAIL fetch_write_count: got %0d expected 0", wr_log.size() - bw); end
        n_checks++;
        if (ibus_input !== W_I1) begin n_fail++; $display("FAIL fetch_data: got %h expected %h", ibus_input, W_I1); end
        n_checks++;
        if (i_done_cnt - bi !== 1) begin n_fail++; $display("FAIL fetch_ibus_done_count: got %0d expected 1", i_done_cnt - bi); end
        n_checks++;
        if (d_done_cnt - bd !== 0) begin n_fail++; $display("FAIL fetch_dbus_done_count: got %0d expected 0", d_done_cnt - bd); end
    endtask

    task automatic test_dual();
        int lat, br, bi, bd;
        logic [14:0] a0, a1;
        apply_reset();
        mem_wait = 0;
        mem_arr[9'o200] = W_D;
        mem_arr[9'o100] = W_I2;
        br = rd_log.size(); bi = i_done_cnt; bd = d_done_cnt;
        do_req(1, 1, 0, 15'o00100, 15'o00200, 48'h0, lat);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a0 = (rd_log.size() > br) ? rd_log[br] : 15'bx;
        a1 = (rd_log.size() > br + 1) ? rd_log[br + 1] : 15'bx;
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL dual_latency: got %0d expected 3", lat); end
        n_checks++;
        if (rd_log.size() - br !== 2) begin n_fail++; $display("FAIL dual_read_count: got %0d expected 2", rd_log.size() - br); end
        n_checks++;
        if (a0 !== 15'o00200 || a1 !== 15'o00100) begin n_fail++; $display("FAIL dual_read_order: got %o,%o expected 00200,00100", a0, a1); end
        n_checks++;
        if (i_done_cnt - bi !== 1 || d_done_cnt - bd !== 1 || i_done_cyc !== d_done_cyc) begin
            n_fail++;
            $display("FAIL dual_done_together: ibus %0d@%0d dbus %0d@%0d expected one each same cycle", i_done_cnt - bi, i_done_cyc, d_done_cnt - bd, d_done_cyc);
        end
        n_checks++;
        if (ibus_input !== W_I2) begin n_fail++; $display("FAIL dual_ibus_data: got %h expected %h", ibus_input, W_I2); end
        n_checks++;
        if (dbus_input !== W_D) begin n_fail++; $display("FAIL dual_dbus_data: got %h expected %h", dbus_input, W_D); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2, c0, br, bw, bd, w_at_done;
        apply_reset();
        mem_wait = 0;
        br = rd_log.size(); bw = wr_log.size(); bd = d_done_cnt;
        @(posedge clk); #1;
        dbus_write = 1'b1; dbus_addr = 15'o00300; dbus_output = W_WR;
        c0 = cyc; lat = -1; w_at_done = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dbus_done) begin lat = cyc - c0; w_at_done = wr_log.size() - bw; break; end
        end
        @(posedge clk); #1;
        c0 = cyc;
        @(posedge clk); #1;
        dbus_write = 1'b0;
        lat2 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dbus_done) begin lat2 = cyc - c0; break; end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
        n_checks++;
        if (w_at_done !== 1) begin n_fail++; $display("FAIL b2b_writes_at_done: got %0d expected 1", w_at_done); end
        n_checks++;
        if (lat2 !== 2) begin n_fail++; $display("FAIL b2b_resample_latency: got %0d expected 2", lat2); end
        n_checks++;
        if (wr_log.size() - bw !== 2 || d_done_cnt - bd !== 2) begin
            n_fail++;
            $display("FAIL b2b_total: writes %0d dones %0d expected 2 and 2", wr_log.size() - bw, d_done_cnt - bd);
        end
        n_checks++;
        if (rd_log.size() - br !== 0) begin n_fail++; $display("FAIL b2b_reads: got %0d expected 0", rd_log.size() - br); end
        n_checks++;
        if (mem_arr[9'o300] !== W_WR) begin n_fail++; $display("FAIL b2b_mem_data: got %h expected %h", mem_arr[9'o300], W_WR); end
        n_checks++;
        if (dbus_input !== 48'h0) begin n_fail++; $display("FAIL b2b_dbus_input: got %h expected 0", dbus_input); end
    endtask

    task automatic test_read_write_both();
        int lat, br, bw;
        logic [14:0] a0;
        apply_reset();
        mem_wait = 0;
        mem_arr[9'o200] = W_D;
        do_req(0, 1, 0, 15'o0, 15'o00200, 48'h0, lat);
        br = rd_log.size(); bw = wr_log.size();
        do_req(0, 1, 1, 15'o0, 15'o00310, W_X, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a0 = (wr_log.size() > bw) ? wr_log[bw] : 15'bx;
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rw_latency: got %0d expected 2", lat); end
        n_checks++;
        if (wr_log.size() - bw !== 1 || rd_log.size() - br !== 0) begin
            n_fail++;
            $display("FAIL rw_op_kind: writes %0d reads %0d expected 1 and 0", wr_log.size() - bw, rd_log.size() - br);
        end
        n_checks++;
        if (a0 !== 15'o00310 || mem_arr[9'o310] !== W_X) begin
            n_fail++;
            $display("FAIL rw_mem: addr %o data %h expected 00310 %h", a0, mem_arr[9'o310], W_X);
        end
        n_checks++;
        if (dbus_input !== W_D) begin n_fail++; $display("FAIL rw_dbus_input: got %h expected %h", dbus_input, W_D); end
    endtask

    task automatic test_reset_mid_op();
        int lat, br, bi, bd;
        apply_reset();
        mem_wait = 0;
        stall = 1'b1;
        br = rd_log.size(); bi = i_done_cnt; bd = d_done_cnt;
        @(posedge clk); #1;
        dbus_read = 1'b1; dbus_addr = 15'o00200;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 15'o00200) begin
            n_fail++;
            $display("FAIL abort_strobe_before: mem_read=%b addr=%o expected 1 00200", mem_read, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b1; dbus_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_strobe_after: mem_read=%b mem_write=%b expected 0 0", mem_read, mem_write);
        end
        stall = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (i_done_cnt - bi !== 0 || d_done_cnt - bd !== 0 || rd_log.size() - br !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: ibus %0d dbus %0d reads %0d expected 0 0 0", i_done_cnt - bi, d_done_cnt - bd, rd_log.size() - br);
        end
        mem_arr[9'o100] = W_I1;
        do_req(1, 0, 0, 15'o00100, 15'o0, 48'h0, lat);
        n_checks++;
        if (lat !== 2 || ibus_input !== W_I1) begin
            n_fail++;
            $display("FAIL abort_recover: lat %0d data %h expected 2 %h", lat, ibus_input, W_I1);
        end
    endtask

`ifdef MESM6_ARB_WORD_CACHE_EN
    task automatic test_word_cache();
        int lat, br;
        apply_reset();
        mem_wait = 0;
        mem_arr[9'o100] = W_I1;
        do_req(1, 0, 0, 15'o00100, 15'o0, 48'h0, lat);
        br = rd_log.size();
        do_req(1, 0, 0, 15'o00100, 15'o0, 48'h0, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL cache_hit_latency: got %0d expected 1", lat); end
        n_checks++;
        if (rd_log.size() - br !== 0) begin n_fail++; $display("FAIL cache_hit_reads: got %0d expected 0", rd_log.size() - br); end
        n_checks++;
        if (ibus_input !== W_I1) begin n_fail++; $display("FAIL cache_hit_data: got %h expected %h", ibus_input, W_I1); end
        do_req(0, 0, 1, 15'o0, 15'o00100, W_I2, lat);
        br = rd_log.size();
        do_req(1, 0, 0, 15'o00100, 15'o0, 48'h0, lat);
        n_checks++;
        if (rd_log.size() - br !== 1 || lat !== 2) begin
            n_fail++;
            $display("FAIL cache_inval_read: reads %0d lat %0d expected 1 2", rd_log.size() - br, lat);
        end
        n_checks++;
        if (ibus_input !== W_I2) begin n_fail++; $display("FAIL cache_inval_data: got %h expected %h", ibus_input, W_I2); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem_arr[i] = 48'h0;
        test_reset();
        test_fetch_only();
        test_dual();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid_op();
`ifdef MESM6_ARB_WORD_CACHE_EN
        test_word_cache();
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
